spi_x_reader: RTL and testbench
===============================

SPI_X_READER -- requirements
Module: spi_x_reader

Interface
REQ-001 Parameter: CLK_DIV, 50, clk cycles per SCLK half-period (legal range 4..255).
REQ-002 Parameter: POLL_CYCLES, 100000, clk cycles from the start of one transaction to the start of the next (at least 40*CLK_DIV).
REQ-003 Parameter: CMD_WORD, 16'h0000, word shifted out on MOSI, MSB first.
REQ-004 Port: clk  input  1  system clock, 100 MHz.
REQ-005 Port: rst  input  1  synchronous, active-high reset.
REQ-006 Port: period_start  input  1  one-cycle pulse marking PWM period start (servo counter wrap to 0).
REQ-007 Port: spi_miso  input  1  slave data, asynchronous to clk.
REQ-008 Port: spi_cs_n  output  1  chip select, active low.
REQ-009 Port: spi_sclk  output  1  SPI clock, mode 0.
REQ-010 Port: spi_mosi  output  1  master data.
REQ-011 Port: x_val  output  11  servo position value, range 1000..2000, consumed by the PWM compare stage.
REQ-012 Port: x_valid  output  1  one-cycle pulse when x_val is loaded with a new value.
REQ-013 Port: busy  output  1  high while the FSM is in any state other than IDLE.

Function
REQ-014 spi_miso SHALL pass through a 2-flop synchronizer before use.
REQ-015 FSM states SHALL be IDLE, SETUP, SHIFT, HOLD and DONE.
REQ-016 A poll counter SHALL run continuously; it wraps at POLL_CYCLES-1, and its wrap moves the FSM from IDLE to SETUP.
REQ-017 SETUP: spi_cs_n low, spi_sclk low, spi_mosi = CMD_WORD[15]; the FSM stays in SETUP for CLK_DIV cycles, then enters SHIFT.
REQ-018 SHIFT: 16 bits; each bit is CLK_DIV cycles with spi_sclk low, followed by CLK_DIV cycles with spi_sclk high.
REQ-019 On the cycle spi_sclk goes 0->1, the synchronized MISO value SHALL be shifted into a 16-bit receive register, MSB first.
REQ-020 On each 1->0 transition of spi_sclk, spi_mosi SHALL present the next CMD_WORD bit; after bit 0, spi_mosi SHALL be 0.
REQ-021 After the 16th high phase, spi_sclk returns low and the FSM enters HOLD.
REQ-022 HOLD: spi_cs_n stays low for CLK_DIV cycles, then goes high and the FSM enters DONE.
REQ-023 DONE: lasts one cycle; it computes raw = rx[9:0] and writes x_pending = 1000 + min(raw, 1000), then returns to IDLE.
REQ-024 Arithmetic SHALL be 11-bit unsigned: raw 0 gives 1000; raw 500 gives 1500; raw 1000..1023 gives 2000.
REQ-025 rx[15:10] SHALL be ignored.
REQ-026 A pending flag SHALL be set in DONE and cleared when x_val loads.
REQ-027 x_val SHALL load x_pending only on a period_start pulse while the pending flag is set; x_valid pulses on the following cycle, coincident with the new x_val.
REQ-028 x_val SHALL NOT change at any other time, so the value is never altered mid PWM period.
REQ-029 If DONE and period_start occur in the same cycle, x_val SHALL load the newly computed value.
REQ-030 A second DONE before any period_start SHALL overwrite x_pending (latest value wins).
REQ-031 A poll wrap that occurs while the FSM is not in IDLE SHALL be ignored; the transaction is not restarted.
REQ-032 spi_sclk, spi_cs_n and spi_mosi SHALL be driven from registers (glitch-free).

Reset
REQ-033 On rst, the FSM SHALL go to IDLE and the poll counter to 0.
REQ-034 Reset values: spi_cs_n=1, spi_sclk=0, spi_mosi=0, x_val=1500, x_pending=1500, pending=0, x_valid=0, busy=0.
REQ-035 rst asserted mid-transaction SHALL abort the transaction in the next cycle (cs_n high, sclk low); partial receive data SHALL be discarded and x_val SHALL NOT be updated.
REQ-036 The first transaction after reset SHALL start POLL_CYCLES cycles after rst deasserts.

Verification
REQ-037 Scenario 1: slave model returns 16'h01F4 (raw 500), then period_start is pulsed -> x_val=1500, x_valid pulses once, 16 SCLK rising edges, each SCLK period = 2*CLK_DIV clk cycles.
REQ-038 Scenario 2: slave returns 16'h0000, then 16'h03E8, then 16'h03FF, with period_start pulsed after each -> x_val=1000, then 2000, then 2000.
REQ-039 Scenario 3: slave returns 16'hFC64 -> upper bits are ignored and x_val=1100.
REQ-040 Scenario 4: two transactions (raw 200, then raw 700) complete with no period_start between them, then period_start is pulsed -> x_val=1700; no x_val change or x_valid before the pulse.
REQ-041 Scenario 5: rst asserted during bit 8 of SHIFT -> the next cycle has cs_n=1 and sclk=0; x_val=1500; the next transaction occurs POLL_CYCLES cycles after rst release.
REQ-042 Scenario 6: CMD_WORD=16'hA5C3 -> the MOSI sequence sampled at SCLK rising edges equals A5C3, MSB first; DONE coincident with period_start -> the new value loads the next cycle.

Source files
------------

// File: rtl/spi_x_reader.sv
// spi_x_reader
//   Periodically polls a SPI slave (mode 0, 16-bit frame) for a position
//   sample, converts the low 10 bits to a servo value in 1000..2000 and hands
//   it to the PWM compare stage only at a PWM period boundary, so the compare
//   value never changes in the middle of a period.
//
// Ports
//   clk           system clock
//   rst           synchronous, active-high reset
//   period_start  one-cycle pulse at PWM period start
//   spi_miso      slave data (asynchronous, synchronized internally)
//   spi_cs_n      chip select, active low (registered)
//   spi_sclk      SPI clock, idle low (registered)
//   spi_mosi      master data, CMD_WORD MSB first (registered)
//   x_val         servo position value, updated only on period_start
//   x_valid       one-cycle pulse coincident with a new x_val
//   busy          high while a transaction is in progress
//
// State | meaning
//   IDLE  | waiting for the poll counter to wrap
//   SETUP | cs_n asserted, first MOSI bit presented, one half-period
//   SHIFT | 16 SCLK periods, sample MISO on rising edge
//   HOLD  | cs_n held low one half-period after the last falling edge
//   DONE  | convert received sample into x_pending (single cycle)

module spi_x_reader #(
  parameter int          CLK_DIV     = 50,
  parameter int          POLL_CYCLES = 100000,
  parameter logic [15:0] CMD_WORD    = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        period_start,
  input  logic        spi_miso,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic [10:0] x_val,
  output logic        x_valid,
  output logic        busy
);

  localparam int         PW       = (POLL_CYCLES > 2) ? $clog2(POLL_CYCLES) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
  localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state_q, state_d;

  logic [PW-1:0] poll_q, poll_d;
  logic          poll_wrap;

  logic          miso_s1_q, miso_s2_q;

  logic [7:0]    div_q, div_d;
  logic          div_tc;
  logic [3:0]    bit_q, bit_d;
  logic [15:0]   rx_q, rx_d;

  logic          cs_n_q, cs_n_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;

  logic [10:0]   x_pending_q, x_pending_d;
  logic          pending_q, pending_d;
  logic [10:0]   x_val_q, x_val_d;
  logic          x_valid_q, x_valid_d;

  logic [9:0]    raw;
  logic [10:0]   raw_sat;
  logic [10:0]   x_new;
  logic          rx_unused;

  // Upper six received bits carry no position information.
  assign rx_unused = ^rx_q[15:10];

  assign poll_wrap = (poll_q == POLL_LAST);
  assign poll_d    = poll_wrap ? '0 : poll_q + 1'b1;
  assign div_tc    = (div_q == 8'd0);

  assign raw     = rx_q[9:0];
  assign raw_sat = (raw > 10'd1000) ? 11'd1000 : {1'b0, raw};
  assign x_new   = 11'd1000 + raw_sat;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a poll wrap outside IDLE is simply not looked at.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (poll_wrap) state_d = SETUP;
      SETUP:   if (div_tc) state_d = SHIFT;
      SHIFT:   if (div_tc && sclk_q && (bit_q == 4'd0)) state_d = HOLD;
      HOLD:    if (div_tc) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next-values. SPI pins are computed one cycle ahead and
  // registered so they change exactly on the edge the FSM changes state.
  always_comb begin
    cs_n_d      = 1'b1;
    sclk_d      = 1'b0;
    mosi_d      = 1'b0;
    div_d       = DIV_LOAD;
    bit_d       = 4'd15;
    rx_d        = rx_q;
    x_pending_d = x_pending_q;
    pending_d   = pending_q;
    x_val_d     = x_val_q;
    x_valid_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (state_d == SETUP) begin
          cs_n_d = 1'b0;
          mosi_d = CMD_WORD[15];
          rx_d   = '0;
        end
      end
      SETUP: begin
        cs_n_d = 1'b0;
        mosi_d = mosi_q;
        div_d  = div_tc ? DIV_LOAD : div_q - 8'd1;
      end
      SHIFT: begin
        cs_n_d = 1'b0;
        sclk_d = sclk_q;
        mosi_d = mosi_q;
        bit_d  = bit_q;
        div_d  = div_tc ? DIV_LOAD : div_q - 8'd1;
        if (div_tc) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[14:0], miso_s2_q};
          end else begin
            sclk_d = 1'b0;
            if (bit_q == 4'd0) begin
              mosi_d = 1'b0;
            end else begin
              mosi_d = CMD_WORD[bit_q - 4'd1];
              bit_d  = bit_q - 4'd1;
            end
          end
        end
      end
      HOLD: begin
        cs_n_d = div_tc;
        div_d  = div_tc ? DIV_LOAD : div_q - 8'd1;
      end
      DONE: begin
        x_pending_d = x_new;
        pending_d   = 1'b1;
      end
      default: begin
      end
    endcase

    // Evaluated after DONE so a coincident period_start takes the fresh value.
    if (period_start && pending_d) begin
      x_val_d   = x_pending_d;
      pending_d = 1'b0;
      x_valid_d = 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      poll_q      <= '0;
      miso_s1_q   <= 1'b0;
      miso_s2_q   <= 1'b0;
      div_q       <= DIV_LOAD;
      bit_q       <= 4'd15;
      rx_q        <= '0;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      x_pending_q <= 11'd1500;
      pending_q   <= 1'b0;
      x_val_q     <= 11'd1500;
      x_valid_q   <= 1'b0;
    end else begin
      poll_q      <= poll_d;
      miso_s1_q   <= spi_miso;
      miso_s2_q   <= miso_s1_q;
      div_q       <= div_d;
      bit_q       <= bit_d;
      rx_q        <= rx_d;
      cs_n_q      <= cs_n_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      x_pending_q <= x_pending_d;
      pending_q   <= pending_d;
      x_val_q     <= x_val_d;
      x_valid_q   <= x_valid_d;
    end
  end

  assign spi_cs_n = cs_n_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;
  assign x_val    = x_val_q;
  assign x_valid  = x_valid_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_spi_x_reader.sv
`timescale 1ns/1ps
module tb_spi_x_reader;

  localparam int          CLK_DIV = 4;
  localparam int          POLL    = 200;
  localparam logic [15:0] CMD     = 16'hA5C3;

  logic        clk = 1'b0;
  logic        rst;
  logic        period_start;
  logic        spi_miso;
  logic        spi_cs_n;
  logic        spi_sclk;
  logic        spi_mosi;
  logic [10:0] x_val;
  logic        x_valid;
  logic        busy;

  always #5 clk = ~clk;

  spi_x_reader #(
    .CLK_DIV    (CLK_DIV),
    .POLL_CYCLES(POLL),
    .CMD_WORD   (CMD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .period_start(period_start),
    .spi_miso    (spi_miso),
    .spi_cs_n    (spi_cs_n),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .x_val       (x_val),
    .x_valid     (x_valid),
    .busy        (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Mode-0 slave: MSB driven at cs_n fall, next bit after each SCLK fall.
  logic [15:0] slave_word = 16'h0000;
  logic [15:0] sl_sh;
  int          rise_cnt = 0;
  int          per_bad  = 0;
  time         last_rise = 0;
  logic [15:0] mosi_cap = 16'h0000;
  int          vcnt = 0;

  always @(negedge spi_cs_n) begin
    sl_sh    = slave_word;
    spi_miso = sl_sh[15];
    rise_cnt = 0;
  end

  always @(negedge spi_sclk) begin
    if (spi_cs_n === 1'b0) begin
      sl_sh    = {sl_sh[14:0], 1'b0};
      spi_miso = sl_sh[15];
    end
  end

  always @(posedge spi_sclk) begin
    if (rise_cnt > 0 && ($time - last_rise) != 2 * CLK_DIV * 10) per_bad++;
    last_rise = $time;
    rise_cnt++;
    mosi_cap = {mosi_cap[14:0], spi_mosi};
  end

  always @(negedge clk) if (x_valid === 1'b1) vcnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse();
    @(negedge clk) period_start = 1'b1;
    @(negedge clk) period_start = 1'b0;
  endtask

  task automatic wait_cs_low();
    int n = 0;
    while (spi_cs_n !== 1'b0 && n < 3 * POLL) begin
      @(negedge clk);
      n++;
    end
    check("cs_fall_timeout", {31'd0, spi_cs_n}, 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("busy_timeout", {31'd0, busy}, 0);
  endtask

  task automatic txn(input logic [15:0] w);
    slave_word = w;
    wait_cs_low();
    check("busy_in_txn", {31'd0, busy}, 1);
    wait_idle();
    check("sclk_rises", rise_cnt, 16);
    check("sclk_period", per_bad, 0);
  endtask

  task automatic measure_start(input string tag);
    int n = 0;
    while (n < 3 * POLL) begin
      @(posedge clk);
      #1;
      n++;
      if (spi_cs_n === 1'b0) break;
    end
    check(tag, n, POLL);
  endtask

  initial begin
    int v0;
    int n;
    rst          = 1'b1;
    period_start = 1'b0;
    spi_miso     = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_cs_n",    {31'd0, spi_cs_n}, 1);
    check("rst_sclk",    {31'd0, spi_sclk}, 0);
    check("rst_mosi",    {31'd0, spi_mosi}, 0);
    check("rst_x_val",   {21'd0, x_val}, 1500);
    check("rst_x_valid", {31'd0, x_valid}, 0);
    check("rst_busy",    {31'd0, busy}, 0);

    // Scenario 1: raw 500, also checks MOSI pattern and SCLK timing
    slave_word = 16'h01F4;
    rst = 1'b0;
    measure_start("first_start_delay");
    wait_idle();
    check("s1_rises", rise_cnt, 16);
    check("s1_period", per_bad, 0);
    check("s1_mosi_seq", {16'd0, mosi_cap}, 32'h0000A5C3);
    check("s1_no_early_valid", vcnt, 0);
    pulse();
    check("s1_x_val", {21'd0, x_val}, 1500);
    check("s1_x_valid", {31'd0, x_valid}, 1);
    @(negedge clk);
    check("s1_valid_once", vcnt, 1);
    check("s1_valid_low", {31'd0, x_valid}, 0);

    // Scenario 2: bounds of the conversion
    txn(16'h0000);
    pulse();
    check("s2_raw0", {21'd0, x_val}, 1000);
    txn(16'h03E8);
    pulse();
    check("s2_raw1000", {21'd0, x_val}, 2000);
    txn(16'h03FF);
    pulse();
    check("s2_raw1023", {21'd0, x_val}, 2000);
    check("s2_raw1023_valid", {31'd0, x_valid}, 1);

    // Scenario 3: upper bits ignored
    txn(16'hFC64);
    pulse();
    check("s3_x_val", {21'd0, x_val}, 1100);

    // Scenario 4: latest value wins, nothing moves before period_start
    @(negedge clk);
    v0 = vcnt;
    txn(16'h00C8);
    txn(16'h02BC);
    check("s4_hold_x_val", {21'd0, x_val}, 1100);
    check("s4_no_valid", vcnt, v0);
    pulse();
    check("s4_x_val", {21'd0, x_val}, 1700);
    check("s4_x_valid", {31'd0, x_valid}, 1);

    // Scenario 6: DONE coincident with period_start
    slave_word = 16'h0320;
    wait_cs_low();
    n = 0;
    while (spi_cs_n !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("s6_done_busy", {31'd0, busy}, 1);
    check("s6_mosi_after", {31'd0, spi_mosi}, 0);
    period_start = 1'b1;
    @(negedge clk);
    period_start = 1'b0;
    check("s6_x_val", {21'd0, x_val}, 1800);
    check("s6_x_valid", {31'd0, x_valid}, 1);
    check("s6_idle", {31'd0, busy}, 0);
    check("s6_mosi_seq", {16'd0, mosi_cap}, 32'h0000A5C3);
    pulse();
    check("s6_no_reload", {31'd0, x_valid}, 0);
    check("s6_x_val_kept", {21'd0, x_val}, 1800);

    // Scenario 5: reset in the middle of SHIFT
    slave_word = 16'h012C;
    wait_cs_low();
    n = 0;
    while (rise_cnt < 8 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("s5_reach_bit8", rise_cnt, 8);
    rst = 1'b1;
    @(negedge clk);
    check("s5_cs_n", {31'd0, spi_cs_n}, 1);
    check("s5_sclk", {31'd0, spi_sclk}, 0);
    check("s5_busy", {31'd0, busy}, 0);
    check("s5_x_val", {21'd0, x_val}, 1500);
    rst = 1'b0;
    measure_start("s5_restart_delay");
    check("s5_x_val_unchanged", {21'd0, x_val}, 1500);
    wait_idle();
    check("s5_rises", rise_cnt, 16);
    pulse();
    check("s5_new_x_val", {21'd0, x_val}, 1300);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
